// File: rtl/mem_pkg.sv
// Shared definitions for the L1 cache to main-memory channel.
package mem_pkg;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              was_write;
    } mem_resp_t;

endpackage

// File: rtl/mem_array.sv
// Single-port RAM: synchronous write, registered read.
// The read register also captures write data, so it always holds the
// data of the most recent access and serves directly as response data.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage write; deliberately unreset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Next read-register value: new data on an access, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = we ? wdata : mem_q[addr];
        end
    end

    // Read/echo data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Backing-store responder for the L1 cache: one request at a time,
// fixed access latency, valid/ready request and response channels.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W  = mem_pkg::DATA_W,
    parameter int unsigned MEM_AW  = 10,
    parameter int          LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_was_write
);

    localparam int unsigned     CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("main_mem_responder: LATENCY must be >= 1");
        end
        // Upper address bits alias onto the same word by design.
        if (ADDR_W > MEM_AW) begin : g_alias
            logic unused_upper_addr;
            assign unused_upper_addr = ^req_addr[ADDR_W-1:MEM_AW];
        end
    endgenerate

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              was_write_q, was_write_d;
    logic              access;

    // State, countdown and captured-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            was_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            was_write_q <= was_write_d;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, await handshake in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        was_write_d = was_write_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[MEM_AW-1:0];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    was_write_d = we_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and the single RAM access strobe.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        access     = (state_q == WAIT) && (cnt_q == '0);
    end

    mem_array #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (access),
        .we    (we_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (resp_rdata)
    );

    assign resp_was_write = was_write_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: a LATENCY=4 instance (index 0) and a
// LATENCY=1 instance (index 1), checked against a word-addressed memory model.
module tb_main_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid      [2];
    logic        req_ready      [2];
    logic        req_we         [2];
    logic [16:0] req_addr       [2];
    logic [31:0] req_wdata      [2];
    logic        resp_valid     [2];
    logic        resp_ready     [2];
    logic [31:0] resp_rdata     [2];
    logic        resp_was_write [2];

    int unsigned n_cmp;
    int unsigned n_err;

    // Expected memory contents, keyed by instance*4096 + word index.
    logic [31:0] model [int unsigned];

    main_mem_responder #(.ADDR_W(17), .DATA_W(32), .MEM_AW(10), .LATENCY(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_was_write(resp_was_write[0])
    );

    main_mem_responder #(.ADDR_W(17), .DATA_W(32), .MEM_AW(10), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_was_write(resp_was_write[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    // Runs one transaction; entered and left at a negedge.
    task automatic txn(input int s, input logic we, input logic [16:0] addr,
                       input logic [31:0] wd, input int hold,
                       output int lat, output logic [31:0] rd, output logic ww,
                       output int busy, output logic stable,
                       output logic post_v, output logic post_r);
        int n;
        req_valid[s]  = 1'b1;
        req_we[s]     = we;
        req_addr[s]   = addr;
        req_wdata[s]  = wd;
        resp_ready[s] = (hold == 0);
        n = 0;
        while (!req_ready[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[s] = 1'b0;
        req_we[s]    = 1'($urandom);
        req_addr[s]  = 17'($urandom);
        req_wdata[s] = $urandom;
        lat  = 0;
        busy = 0;
        while (!resp_valid[s] && lat < 200) begin
            if (!req_ready[s]) busy++;
            @(negedge clk);
            lat++;
        end
        rd     = resp_rdata[s];
        ww     = resp_was_write[s];
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (!req_ready[s]) busy++;
            @(negedge clk);
            if (resp_valid[s] !== 1'b1 || resp_rdata[s] !== rd ||
                resp_was_write[s] !== ww || req_ready[s] !== 1'b0) stable = 1'b0;
        end
        if (!req_ready[s]) busy++;
        resp_ready[s] = 1'b1;
        @(negedge clk);
        post_v = resp_valid[s];
        post_r = req_ready[s];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
            req_wdata[s] = '0; resp_ready[s] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (req_ready[s] !== 1'b1) begin
                n_err++; $display("FAIL reset_req_ready[%0d]: got %b expected 1", s, req_ready[s]);
            end
            n_cmp++;
            if (resp_valid[s] !== 1'b0) begin
                n_err++; $display("FAIL reset_resp_valid[%0d]: got %b expected 0", s, resp_valid[s]);
            end
            n_cmp++;
            if (resp_rdata[s] !== 32'h0) begin
                n_err++; $display("FAIL reset_resp_rdata[%0d]: got %h expected 0", s, resp_rdata[s]);
            end
            n_cmp++;
            if (resp_was_write[s] !== 1'b0) begin
                n_err++; $display("FAIL reset_was_write[%0d]: got %b expected 0", s, resp_was_write[s]);
            end
        end
    endtask

    task automatic test_write_read();
        int lat, busy; logic [31:0] rd; logic ww, st, pv, pr;
        txn(0, 1'b1, 17'h00003, 32'h0000003F, 0, lat, rd, ww, busy, st, pv, pr);
        model[3] = 32'h0000003F;
        n_cmp++;
        if (lat != 4) begin n_err++; $display("FAIL wr_latency: got %0d expected 4", lat); end
        n_cmp++;
        if (ww !== 1'b1) begin n_err++; $display("FAIL wr_was_write: got %b expected 1", ww); end
        n_cmp++;
        if (rd !== 32'h3F) begin n_err++; $display("FAIL wr_echo: got %h expected 0000003f", rd); end
        n_cmp++;
        if (busy != 5) begin n_err++; $display("FAIL wr_busy: got %0d expected 5", busy); end
        txn(0, 1'b0, 17'h00003, 32'hFFFF0000, 0, lat, rd, ww, busy, st, pv, pr);
        n_cmp++;
        if (rd !== 32'h3F) begin n_err++; $display("FAIL rd_data: got %h expected 0000003f", rd); end
        n_cmp++;
        if (ww !== 1'b0) begin n_err++; $display("FAIL rd_was_write: got %b expected 0", ww); end
        n_cmp++;
        if (lat != 4) begin n_err++; $display("FAIL rd_latency: got %0d expected 4", lat); end
        n_cmp++;
        if (busy != 5) begin n_err++; $display("FAIL rd_busy: got %0d expected 5", busy); end
        n_cmp++;
        if (pv !== 1'b0 || pr !== 1'b1) begin
            n_err++; $display("FAIL rd_release: got valid=%b ready=%b expected valid=0 ready=1", pv, pr);
        end
    endtask

    task automatic test_aliasing();
        int lat, busy; logic [31:0] rd; logic ww, st, pv, pr;
        txn(0, 1'b1, 17'h00033, 32'h00003C3C, 0, lat, rd, ww, busy, st, pv, pr);
        txn(0, 1'b1, 17'h1C033, 32'h01FE3C3C, 0, lat, rd, ww, busy, st, pv, pr);
        model[10'h033] = 32'h01FE3C3C;
        txn(0, 1'b0, 17'h00033, 32'h0, 0, lat, rd, ww, busy, st, pv, pr);
        n_cmp++;
        if (rd !== 32'h01FE3C3C) begin n_err++; $display("FAIL alias_data: got %h expected 01fe3c3c", rd); end
    endtask

    task automatic test_backpressure();
        int lat, busy; logic [31:0] rd; logic ww, st, pv, pr;
        txn(0, 1'b0, 17'h00003, 32'h0, 6, lat, rd, ww, busy, st, pv, pr);
        n_cmp++;
        if (rd !== 32'h3F) begin n_err++; $display("FAIL bp_data: got %h expected 0000003f", rd); end
        n_cmp++;
        if (st !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b expected 1", st); end
        n_cmp++;
        if (busy != 11) begin n_err++; $display("FAIL bp_busy: got %0d expected 11", busy); end
        n_cmp++;
        if (pv !== 1'b0 || pr !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", pv, pr);
        end
    endtask

    task automatic test_request_while_busy();
        int lat, busy, n; logic [31:0] rd; logic ww, st, pv, pr, early;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 17'h00033;
        req_wdata[0] = $urandom; resp_ready[0] = 1'b1;
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 17'h00005; req_wdata[0] = 32'hAAAA5555;
        n = 0; early = 1'b0;
        while (!resp_valid[0] && n < 200) begin
            if (req_ready[0]) early = 1'b1;
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != 4) begin n_err++; $display("FAIL busy_first_latency: got %0d expected 4", n); end
        n_cmp++;
        if (early !== 1'b0) begin n_err++; $display("FAIL busy_ready_low: got %b expected 0", early); end
        n_cmp++;
        if (resp_rdata[0] !== 32'h01FE3C3C || resp_was_write[0] !== 1'b0) begin
            n_err++; $display("FAIL busy_first_resp: got %h/%b expected 01fe3c3c/0", resp_rdata[0], resp_was_write[0]);
        end
        txn(0, 1'b1, 17'h00005, 32'hAAAA5555, 0, lat, rd, ww, busy, st, pv, pr);
        model[5] = 32'hAAAA5555;
        n_cmp++;
        if (lat != 4 || rd !== 32'hAAAA5555 || ww !== 1'b1) begin
            n_err++; $display("FAIL busy_second: got lat=%0d %h/%b expected lat=4 aaaa5555/1", lat, rd, ww);
        end
        txn(0, 1'b0, 17'h00005, 32'h0, 0, lat, rd, ww, busy, st, pv, pr);
        n_cmp++;
        if (rd !== 32'hAAAA5555) begin n_err++; $display("FAIL busy_readback: got %h expected aaaa5555", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat, busy; logic [31:0] rd; logic ww, st, pv, pr;
        txn(0, 1'b1, 17'h00007, 32'h11111111, 0, lat, rd, ww, busy, st, pv, pr);
        model[7] = 32'h11111111;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 17'h00007; req_wdata[0] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || resp_rdata[0] !== 32'h0 ||
            resp_was_write[0] !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_outputs: got v=%b r=%b d=%h w=%b expected v=0 r=1 d=0 w=0",
                resp_valid[0], req_ready[0], resp_rdata[0], resp_was_write[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 17'h00007, 32'h0, 0, lat, rd, ww, busy, st, pv, pr);
        n_cmp++;
        if (rd !== 32'h11111111) begin n_err++; $display("FAIL rst_mid_uncommitted: got %h expected 11111111", rd); end
        txn(0, 1'b0, 17'h00003, 32'h0, 0, lat, rd, ww, busy, st, pv, pr);
        n_cmp++;
        if (rd !== 32'h3F) begin n_err++; $display("FAIL rst_mid_preserved: got %h expected 0000003f", rd); end
    endtask

    task automatic test_latency1();
        int lat, busy; logic [31:0] rd; logic ww, st, pv, pr;
        txn(1, 1'b1, 17'h00001, 32'h12345678, 0, lat, rd, ww, busy, st, pv, pr);
        model[4096 + 1] = 32'h12345678;
        n_cmp++;
        if (lat != 1 || ww !== 1'b1) begin
            n_err++; $display("FAIL l1_write: got lat=%0d w=%b expected lat=1 w=1", lat, ww);
        end
        txn(1, 1'b0, 17'h00001, 32'h0, 0, lat, rd, ww, busy, st, pv, pr);
        n_cmp++;
        if (lat != 1 || rd !== 32'h12345678 || busy != 2) begin
            n_err++; $display("FAIL l1_read: got lat=%0d d=%h busy=%0d expected lat=1 d=12345678 busy=2", lat, rd, busy);
        end
    endtask

    task automatic test_random();
        int lat, busy, hold, s, exp_lat; logic [31:0] rd, wd, exp_rd; logic ww, st, pv, pr, we;
        logic [9:0] idx; logic [16:0] addr; int unsigned key;
        for (int t = 0; t < 60; t++) begin
            s    = (t % 4 == 3) ? 1 : 0;
            idx  = 10'($urandom_range(0, 15));
            addr = {7'($urandom), idx};
            key  = 32'(s) * 4096 + 32'(idx);
            we   = 1'($urandom) || !model.exists(key);
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            exp_lat = (s == 0) ? 4 : 1;
            exp_rd  = we ? wd : model[key];
            txn(s, we, addr, wd, hold, lat, rd, ww, busy, st, pv, pr);
            if (we) model[key] = wd;
            n_cmp++;
            if (rd !== exp_rd || ww !== we) begin
                n_err++; $display("FAIL rnd_data[%0d]: got %h/%b expected %h/%b", t, rd, ww, exp_rd, we);
            end
            n_cmp++;
            if (lat != exp_lat || busy != exp_lat + 1 + hold || st !== 1'b1 || pv !== 1'b0 || pr !== 1'b1) begin
                n_err++; $display("FAIL rnd_timing[%0d]: got lat=%0d busy=%0d st=%b v=%b r=%b expected lat=%0d busy=%0d st=1 v=0 r=1",
                    t, lat, busy, st, pv, pr, exp_lat, exp_lat + 1 + hold);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_aliasing();
        test_backpressure();
        test_request_while_busy();
        test_reset_mid_write();
        test_latency1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
